// File: rtl/ga_init_loader.sv
// ga_init_loader: host-side transmitter for the GA core's initial-population
// load handshake. It starts one job, feeds one chromosome per core acknowledge
// from either a 2-entry prefetch FIFO on the upstream stream or a seeded
// Galois LFSR, then holds start_ga until the core reports done.
module ga_init_loader #(
    parameter int CHROMOSOME_WIDTH = 16,
    parameter int POPULATION_SIZE  = 100,
    parameter int ADDR_WIDTH       = $clog2(POPULATION_SIZE)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        cfg_start,
    input  logic                        cfg_abort,
    input  logic [ADDR_WIDTH-1:0]       cfg_population_size,
    input  logic                        cfg_use_lfsr,
    input  logic [CHROMOSOME_WIDTH-1:0] cfg_seed,
    input  logic                        s_valid,
    input  logic [CHROMOSOME_WIDTH-1:0] s_data,
    output logic                        s_ready,
    output logic                        start_ga,
    output logic                        load_initial_population,
    output logic [CHROMOSOME_WIDTH-1:0] data_in,
    input  logic                        load_data_now,
    input  logic                        ga_done,
    output logic                        busy,
    output logic [ADDR_WIDTH:0]         loaded_count,
    output logic                        load_complete,
    output logic                        underrun_err,
    output logic                        cfg_err
);

    typedef enum logic [1:0] {IDLE, PREFETCH, LOAD, RUN} state_t;

    localparam logic [ADDR_WIDTH:0] MAX_SIZE = (ADDR_WIDTH+1)'(POPULATION_SIZE);
    localparam logic [CHROMOSOME_WIDTH-1:0] LFSR_TAPS = CHROMOSOME_WIDTH'(16'hB400);

    state_t                        state_q;
    logic [ADDR_WIDTH-1:0]         size_q;
    logic                          useLfsr_q;
    logic [CHROMOSOME_WIDTH-1:0]   seed_q;
    logic [CHROMOSOME_WIDTH-1:0]   data_q;
    logic                          startGa_q;
    logic                          loadInit_q;
    logic [ADDR_WIDTH:0]           loadedCount_q;
    logic                          loadComplete_q;
    logic                          underrun_q;
    logic                          cfgErr_q;
    logic                          pending_q;

    logic [CHROMOSOME_WIDTH-1:0]   fifoMem_q [2];
    logic                          fifoWr_q;
    logic                          fifoRd_q;
    logic [1:0]                    fifoCount_q;
    logic [ADDR_WIDTH:0]           fetched_q;

    logic                          fifoEmpty;
    logic                          fifoFull;
    logic [CHROMOSOME_WIDTH-1:0]   fifoHead;
    logic [ADDR_WIDTH:0]           countInc;
    logic                          lastAck;
    logic                          wantNext;
    logic                          sReady;
    logic                          fifoPush;
    logic                          fifoPop;
    logic                          fifoFlush;
    logic                          sizeOk;

    // One step of the right-shifting Galois LFSR.
    function automatic logic [CHROMOSOME_WIDTH-1:0] lfsrStep(input logic [CHROMOSOME_WIDTH-1:0] x);
        lfsrStep = x[0] ? ((x >> 1) ^ LFSR_TAPS) : (x >> 1);
    endfunction

    // Decode FIFO status, acknowledge meaning and the push/pop/flush strobes.
    always_comb begin
        fifoEmpty = (fifoCount_q == 2'd0);
        fifoFull  = (fifoCount_q == 2'd2);
        fifoHead  = fifoMem_q[fifoRd_q];
        countInc  = loadedCount_q + 1'b1;
        lastAck   = load_data_now && (countInc == {1'b0, size_q});
        wantNext  = (state_q == LOAD) && !lastAck && (load_data_now || pending_q);
        sReady    = !fifoFull && ((state_q == PREFETCH) || (state_q == LOAD)) &&
                    !useLfsr_q && (fetched_q < {1'b0, size_q});
        fifoPush  = s_valid && sReady;
        fifoPop   = !cfg_abort && !useLfsr_q && !fifoEmpty &&
                    ((state_q == PREFETCH) || wantNext);
        fifoFlush = cfg_abort || (state_q == IDLE) || ((state_q == RUN) && ga_done);
        sizeOk    = (cfg_population_size != '0) && ({1'b0, cfg_population_size} <= MAX_SIZE);
    end

    // Two-entry prefetch FIFO plus the count of words pulled from upstream; emptied whenever the loader is idle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fifoMem_q[0] <= '0;
            fifoMem_q[1] <= '0;
            fifoWr_q     <= 1'b0;
            fifoRd_q     <= 1'b0;
            fifoCount_q  <= 2'd0;
            fetched_q    <= '0;
        end else if (fifoFlush) begin
            fifoWr_q     <= 1'b0;
            fifoRd_q     <= 1'b0;
            fifoCount_q  <= 2'd0;
            fetched_q    <= '0;
        end else begin
            if (fifoPush) begin
                fifoMem_q[fifoWr_q] <= s_data;
                fifoWr_q            <= ~fifoWr_q;
                fetched_q           <= fetched_q + 1'b1;
            end
            if (fifoPop) begin
                fifoRd_q <= ~fifoRd_q;
            end
            fifoCount_q <= fifoCount_q + 2'(fifoPush) - 2'(fifoPop);
        end
    end

    // Job sequencer with all handshake and status outputs registered here.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= IDLE;
            size_q         <= '0;
            useLfsr_q      <= 1'b0;
            seed_q         <= '0;
            data_q         <= '0;
            startGa_q      <= 1'b0;
            loadInit_q     <= 1'b0;
            loadedCount_q  <= '0;
            loadComplete_q <= 1'b0;
            underrun_q     <= 1'b0;
            cfgErr_q       <= 1'b0;
            pending_q      <= 1'b0;
        end else begin
            loadComplete_q <= 1'b0;
            cfgErr_q       <= 1'b0;
            if (cfg_abort) begin
                state_q    <= IDLE;
                startGa_q  <= 1'b0;
                loadInit_q <= 1'b0;
                pending_q  <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (cfg_start) begin
                            if (sizeOk) begin
                                size_q        <= cfg_population_size;
                                useLfsr_q     <= cfg_use_lfsr;
                                seed_q        <= (cfg_seed == '0) ? CHROMOSOME_WIDTH'(1) : cfg_seed;
                                loadedCount_q <= '0;
                                underrun_q    <= 1'b0;
                                pending_q     <= 1'b0;
                                state_q       <= PREFETCH;
                            end else begin
                                cfgErr_q <= 1'b1;
                            end
                        end
                    end
                    PREFETCH: begin
                        if (useLfsr_q || !fifoEmpty) begin
                            data_q     <= useLfsr_q ? seed_q : fifoHead;
                            startGa_q  <= 1'b1;
                            loadInit_q <= 1'b1;
                            state_q    <= LOAD;
                        end
                    end
                    LOAD: begin
                        if (load_data_now) begin
                            loadedCount_q <= countInc;
                        end
                        if (lastAck) begin
                            loadInit_q     <= 1'b0;
                            loadComplete_q <= 1'b1;
                            pending_q      <= 1'b0;
                            state_q        <= RUN;
                        end else if (wantNext) begin
                            if (useLfsr_q) begin
                                data_q <= lfsrStep(data_q);
                            end else if (!fifoEmpty) begin
                                data_q    <= fifoHead;
                                pending_q <= 1'b0;
                            end else begin
                                pending_q <= 1'b1;
                                if (load_data_now) begin
                                    underrun_q <= 1'b1;
                                end
                            end
                        end
                    end
                    RUN: begin
                        if (ga_done) begin
                            startGa_q <= 1'b0;
                            state_q   <= IDLE;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign s_ready                 = sReady;
    assign start_ga                = startGa_q;
    assign load_initial_population = loadInit_q;
    assign data_in                 = data_q;
    assign busy                    = (state_q != IDLE);
    assign loaded_count            = loadedCount_q;
    assign load_complete           = loadComplete_q;
    assign underrun_err            = underrun_q;
    assign cfg_err                 = cfgErr_q;

endmodule

// File: tb/tb_ga_init_loader.sv
// tb_ga_init_loader: directed bench for ga_init_loader covering stream and
// LFSR loads, underrun recovery, rejected sizes, abort, mid-job reset and RUN.
module tb_ga_init_loader;

    localparam int CW = 16;
    localparam int PS = 100;
    localparam int AW = $clog2(PS);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cfg_start = 1'b0;
    logic          cfg_abort = 1'b0;
    logic [AW-1:0] cfg_population_size = '0;
    logic          cfg_use_lfsr = 1'b0;
    logic [CW-1:0] cfg_seed = '0;
    logic          s_valid;
    logic [CW-1:0] s_data;
    logic          s_ready;
    logic          start_ga;
    logic          load_initial_population;
    logic [CW-1:0] data_in;
    logic          load_data_now = 1'b0;
    logic          ga_done = 1'b0;
    logic          busy;
    logic [AW:0]   loaded_count;
    logic          load_complete;
    logic          underrun_err;
    logic          cfg_err;

    int testCount = 0;
    int failCount = 0;

    logic [CW-1:0] words [64];
    int            prodIdx = 0;
    int            prodLimit = 0;
    logic [CW-1:0] expWord;
    logic [CW-1:0] lfsrHand [3];

    ga_init_loader #(.CHROMOSOME_WIDTH(CW), .POPULATION_SIZE(PS), .ADDR_WIDTH(AW)) dut (
        .clk                     (clk),
        .rst                     (rst),
        .cfg_start               (cfg_start),
        .cfg_abort               (cfg_abort),
        .cfg_population_size     (cfg_population_size),
        .cfg_use_lfsr            (cfg_use_lfsr),
        .cfg_seed                (cfg_seed),
        .s_valid                 (s_valid),
        .s_data                  (s_data),
        .s_ready                 (s_ready),
        .start_ga                (start_ga),
        .load_initial_population (load_initial_population),
        .data_in                 (data_in),
        .load_data_now           (load_data_now),
        .ga_done                 (ga_done),
        .busy                    (busy),
        .loaded_count            (loaded_count),
        .load_complete           (load_complete),
        .underrun_err            (underrun_err),
        .cfg_err                 (cfg_err)
    );

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    // Upstream producer offers words[prodIdx] until prodLimit is reached.
    assign s_valid = (prodIdx < prodLimit);
    assign s_data  = words[prodIdx[5:0]];

    // Advance the producer on every completed stream transfer.
    always @(posedge clk) begin
        if (s_valid && s_ready) prodIdx <= prodIdx + 1;
    end

    // Hard stop in case the sequence ever stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [CW-1:0] lfsrModel(input logic [CW-1:0] x);
        lfsrModel = x[0] ? ((x >> 1) ^ 16'hB400) : (x >> 1);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic start, input logic abort, input logic ack, input logic done);
        cfg_start     = start;
        cfg_abort     = abort;
        load_data_now = ack;
        ga_done       = done;
    endtask

    task automatic startJob(input logic [AW-1:0] size, input logic useLfsr, input logic [CW-1:0] seed);
        cfg_population_size = size;
        cfg_use_lfsr        = useLfsr;
        cfg_seed            = seed;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic ackOnce();
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Directed sequence of all scenarios.
    initial begin
        words[0] = 16'h0300; words[1] = 16'h0101; words[2] = 16'h0010;
        words[3] = 16'h2001; words[4] = 16'h0003; words[5] = 16'h3004;
        words[6] = 16'h0300; words[7] = 16'h0101; words[8] = 16'h0010; words[9] = 16'h2001;
        for (int i = 10; i < 64; i++) words[i] = 16'h1000 + 16'(i);
        lfsrHand[0] = 16'h0001; lfsrHand[1] = 16'hB400; lfsrHand[2] = 16'h5A00;

        // Reset values
        #1 rst = 1'b0;
        #2;
        checkOutput("rst_start_ga", 32'(start_ga), 0);
        checkOutput("rst_load_init", 32'(load_initial_population), 0);
        checkOutput("rst_data_in", 32'(data_in), 0);
        checkOutput("rst_s_ready", 32'(s_ready), 0);
        checkOutput("rst_busy", 32'(busy), 0);
        checkOutput("rst_loaded_count", 32'(loaded_count), 0);
        checkOutput("rst_flags", {29'd0, load_complete, underrun_err, cfg_err}, 0);
        tick();
        tick();
        rst = 1'b1;
        tick();

        // Acknowledge ignored in IDLE
        ackOnce();
        checkOutput("idle_ack_count", 32'(loaded_count), 0);
        checkOutput("idle_ack_busy", 32'(busy), 0);

        // Stream, size 6, acknowledge every 4 cycles
        prodLimit = 8;
        startJob(7'd6, 1'b0, 16'h0000);
        checkOutput("s6_busy", 32'(busy), 1);
        checkOutput("s6_start_T", 32'(start_ga), 0);
        tick();
        checkOutput("s6_start_T1", 32'(start_ga), 0);
        tick();
        checkOutput("s6_start_T2", 32'(start_ga), 1);
        checkOutput("s6_load_init_T2", 32'(load_initial_population), 1);
        for (int k = 0; k < 6; k++) begin
            checkOutput($sformatf("s6_data_%0d", k), 32'(data_in), 32'(words[k]));
            ackOnce();
            checkOutput($sformatf("s6_count_%0d", k), 32'(loaded_count), k + 1);
            checkOutput($sformatf("s6_complete_%0d", k), 32'(load_complete), (k == 5) ? 1 : 0);
            checkOutput($sformatf("s6_load_init_%0d", k), 32'(load_initial_population), (k == 5) ? 0 : 1);
            tick(); tick(); tick();
        end
        checkOutput("s6_complete_once", 32'(load_complete), 0);
        checkOutput("s6_data_hold", 32'(data_in), 32'h3004);
        checkOutput("s6_s_ready_done", 32'(s_ready), 0);
        checkOutput("s6_fetched", prodIdx, 6);
        checkOutput("s6_run_start", 32'(start_ga), 1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("s6_done_start", 32'(start_ga), 0);
        checkOutput("s6_done_busy", 32'(busy), 0);

        // LFSR, seed 0, size 10, then RUN to done
        startJob(7'd10, 1'b1, 16'h0000);
        checkOutput("l10_start_T", 32'(start_ga), 0);
        checkOutput("l10_s_ready", 32'(s_ready), 0);
        tick();
        checkOutput("l10_start_T1", 32'(start_ga), 1);
        checkOutput("l10_load_init_T1", 32'(load_initial_population), 1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("l10_done_ignored", 32'(start_ga), 1);
        expWord = 16'h0001;
        for (int k = 0; k < 10; k++) begin
            if (k < 3) checkOutput($sformatf("l10_hand_%0d", k), 32'(data_in), 32'(lfsrHand[k]));
            else       checkOutput($sformatf("l10_data_%0d", k), 32'(data_in), 32'(expWord));
            ackOnce();
            if (k == 9) begin
                checkOutput("l10_complete", 32'(load_complete), 1);
                checkOutput("l10_count", 32'(loaded_count), 10);
                checkOutput("l10_data_hold", 32'(data_in), 32'(expWord));
            end else begin
                expWord = lfsrModel(expWord);
            end
            tick();
        end
        ackOnce();
        checkOutput("l10_run_ack_ignored", 32'(loaded_count), 10);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("l10_done_start", 32'(start_ga), 0);
        checkOutput("l10_done_busy", 32'(busy), 0);

        // Underrun: stream stalls after 3 words
        prodLimit = 9;
        startJob(7'd5, 1'b0, 16'h0000);
        checkOutput("ur_accept", 32'(busy), 1);
        tick(); tick();
        checkOutput("ur_data_0", 32'(data_in), 32'h0300);
        tick(); tick();
        ackOnce();
        checkOutput("ur_data_1", 32'(data_in), 32'h0101);
        tick();
        ackOnce();
        checkOutput("ur_data_2", 32'(data_in), 32'h0010);
        checkOutput("ur_flag_clear", 32'(underrun_err), 0);
        tick();
        ackOnce();
        checkOutput("ur_data_hold", 32'(data_in), 32'h0010);
        checkOutput("ur_flag_set", 32'(underrun_err), 1);
        checkOutput("ur_count", 32'(loaded_count), 3);
        tick(); tick();
        checkOutput("ur_data_still", 32'(data_in), 32'h0010);
        prodLimit = 10;
        tick(); tick();
        checkOutput("ur_data_3", 32'(data_in), 32'h2001);
        checkOutput("ur_flag_sticky", 32'(underrun_err), 1);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("ur_abort_busy", 32'(busy), 0);
        checkOutput("ur_abort_start", 32'(start_ga), 0);
        checkOutput("ur_flag_after_abort", 32'(underrun_err), 1);

        // Rejected sizes 0 and 101
        startJob(7'd0, 1'b0, 16'h0000);
        checkOutput("rej0_cfg_err", 32'(cfg_err), 1);
        checkOutput("rej0_busy", 32'(busy), 0);
        tick();
        checkOutput("rej0_cfg_err_pulse", 32'(cfg_err), 0);
        startJob(7'd101, 1'b0, 16'h0000);
        checkOutput("rej101_cfg_err", 32'(cfg_err), 1);
        checkOutput("rej101_busy", 32'(busy), 0);
        checkOutput("rej_keeps_underrun", 32'(underrun_err), 1);
        tick();
        checkOutput("rej101_cfg_err_pulse", 32'(cfg_err), 0);

        // Size 100 accepted on stream; abort during the 3rd acknowledge
        prodLimit = 64;
        startJob(7'd100, 1'b0, 16'h0000);
        checkOutput("s100_cfg_err", 32'(cfg_err), 0);
        checkOutput("s100_busy", 32'(busy), 1);
        checkOutput("s100_underrun_cleared", 32'(underrun_err), 0);
        tick(); tick();
        checkOutput("s100_data_0", 32'(data_in), 32'h100A);
        tick();
        ackOnce();
        checkOutput("s100_data_1", 32'(data_in), 32'h100B);
        tick();
        ackOnce();
        checkOutput("s100_data_2", 32'(data_in), 32'h100C);
        tick();
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("abort_busy", 32'(busy), 0);
        checkOutput("abort_start", 32'(start_ga), 0);
        checkOutput("abort_load_init", 32'(load_initial_population), 0);
        checkOutput("abort_count", 32'(loaded_count), 2);
        checkOutput("abort_s_ready", 32'(s_ready), 0);

        // New stream job sees no stale FIFO words
        startJob(7'd2, 1'b0, 16'h0000);
        tick(); tick();
        checkOutput("flush_data_0", 32'(data_in), 32'h100F);
        ackOnce();
        checkOutput("flush_data_1", 32'(data_in), 32'h1010);
        tick();
        ackOnce();
        checkOutput("flush_complete", 32'(load_complete), 1);
        checkOutput("flush_count", 32'(loaded_count), 2);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("flush_done_busy", 32'(busy), 0);

        // Asynchronous reset during LOAD
        startJob(7'd5, 1'b1, 16'hACE1);
        tick();
        checkOutput("mr_pre_start", 32'(start_ga), 1);
        checkOutput("mr_pre_data", 32'(data_in), 32'hACE1);
        #3 rst = 1'b0;
        #1;
        checkOutput("mr_start", 32'(start_ga), 0);
        checkOutput("mr_load_init", 32'(load_initial_population), 0);
        checkOutput("mr_data", 32'(data_in), 0);
        checkOutput("mr_busy", 32'(busy), 0);
        tick();
        rst = 1'b1;
        tick(); tick();
        checkOutput("mr_stays_idle", 32'(busy), 0);
        checkOutput("mr_start_after", 32'(start_ga), 0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule

// File: doc/ga_init_loader.md
# ga_init_loader

Host-side transmitter for the GA core's initial-population load handshake. It runs one GA job from a single start pulse. It asserts `start_ga` and `load_initial_population` toward `ga_top`, and presents one chromosome per `load_data_now` acknowledge. Chromosomes come either from an upstream valid/ready stream (through a 2-entry prefetch FIFO) or from an internal seeded LFSR. It then holds `start_ga` until the core reports `done`.

## Interface
- `CHROMOSOME_WIDTH`, 16: chromosome width; LFSR mode requires 16.
- `POPULATION_SIZE`, 100: maximum population accepted.
- `ADDR_WIDTH`, `$clog2(POPULATION_SIZE)`: width of the population-size field.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `cfg_start` in 1: one-cycle start request, honoured only in IDLE.
- `cfg_abort` in 1: return to IDLE from any state.
- `cfg_population_size` in ADDR_WIDTH: number of words to load, sampled on accepted start.
- `cfg_use_lfsr` in 1: 1 selects LFSR source, 0 selects stream; sampled on start.
- `cfg_seed` in CHROMOSOME_WIDTH: LFSR seed; 0 is replaced by 0x0001.
- `s_valid` in 1, `s_data` in CHROMOSOME_WIDTH, `s_ready` out 1: upstream chromosome stream.
- `start_ga` out 1, `load_initial_population` out 1, `data_in` out CHROMOSOME_WIDTH: drive `ga_top`.
- `load_data_now` in 1: core acknowledge, current `data_in` consumed.
- `ga_done` in 1: core job complete.
- `busy` out 1: high whenever state is not IDLE.
- `loaded_count` out ADDR_WIDTH+1: words acknowledged in the current job.
- `load_complete` out 1: one-cycle pulse after the last acknowledge.
- `underrun_err` out 1: sticky flag, cleared on the next accepted start.
- `cfg_err` out 1: one-cycle pulse on a rejected start.

## Operation
- States: IDLE, PREFETCH, LOAD, RUN.
- **IDLE, on `cfg_start`:**
  - Size 0 or > POPULATION_SIZE: pulse `cfg_err`, stay in IDLE.
  - Otherwise: latch the config, clear `loaded_count`, clear `underrun_err`, go to PREFETCH.
- **PREFETCH:**
  - Stream mode: wait for the FIFO head to be valid.
  - LFSR mode: the head is the adjusted seed.
  - When the head is available: load `data_in` with it, assert `start_ga` and `load_initial_population`, go to LOAD.
- **LOAD, on `load_data_now`=1:**
  - Increment `loaded_count`.
  - If the new count equals the size: deassert `load_initial_population`, pulse `load_complete`, go to RUN. `data_in` holds the last word.
  - Otherwise: `data_in` takes the next word (FIFO pop or LFSR step).
  - If no next word is available: set `underrun_err`, keep `data_in` unchanged, and present the next word as soon as it becomes available.
- **RUN:** on `ga_done`=1, clear `start_ga` and go to IDLE.
- **Stream fetch:** `s_ready` = FIFO not full AND state is PREFETCH or LOAD AND stream mode AND words fetched < size. The loader never over-fetches beyond the configured size.
- **LFSR:** 16-bit Galois, right shift. If lsb=1: next = (x>>1) ^ 0xB400; else next = x>>1. One step per consumed word.
- **Abort and IDLE entry:** `cfg_abort` forces IDLE at the next edge with all control outputs 0. Entering IDLE by any path flushes the FIFO and the fetched counter.
- `load_data_now` is ignored outside LOAD. `ga_done` is ignored outside RUN.
- `cfg_abort` takes priority over every other event in the same cycle.

## Timing
- Reset values: all outputs 0, including `s_ready` and `data_in`. State is IDLE.
- Start latency:
  - Start accepted at edge T; PREFETCH from T.
  - LFSR mode: `start_ga`, `load_initial_population` and the first `data_in` are all valid from edge T+1.
  - Stream mode: earliest is edge T+2 (first stream transfer at T+1, FIFO head registered at T+2).
- Next word: registered one edge after the `load_data_now` cycle. The core must space acknowledges by at least 2 cycles; the FIFO sustains this rate when `s_valid` stays high.
- `load_initial_population` falls at the edge after the final acknowledge. `load_complete` is high for exactly that one cycle.
- `start_ga` falls at the edge after `ga_done` is sampled in RUN.
- `cfg_err` is high for exactly one cycle.
- Reset mid-job: all outputs drop asynchronously; a new start is required after reset release.

## Test plan
- **Stream, size 6:** words 0x0300, 0x0101, 0x0010, 0x2001, 0x0003, 0x3004; acknowledge every 4 cycles.
  - `data_in` follows that order.
  - After the 6th acknowledge: `loaded_count`=6, `load_complete` pulses once, `load_initial_population`=0.
  - `s_ready` stays 0 after 6 fetches.
- **LFSR, seed 0:** `data_in` sequence 0x0001, 0xB400, 0x5A00; `start_ga` rises at T+1.
- **Underrun:** stream stalls after 3 words, then acknowledge the 3rd.
  - `data_in` holds 0x0010 and `underrun_err`=1.
  - 4th word arrives: `data_in`=0x2001; `underrun_err` stays 1 until the next start.
- **Rejected size:** `cfg_start` with size 0, or with POPULATION_SIZE+1 (POPULATION_SIZE=100, so 101 is representable in 7 bits).
  - `cfg_err` pulses once; `busy`=0.
  - Size 100 is accepted.
- **Abort and reset:** `cfg_abort` during the 3rd acknowledge.
  - Next edge: IDLE, `start_ga`=0, FIFO flushed, `loaded_count`=2.
  - `rst`=0 during LOAD: all outputs 0 immediately.
- **RUN to done:** after a size-10 load, `ga_done` pulse → `start_ga`=0 next edge; `busy`=0; a new `cfg_start` is accepted.
